// File: rtl/fila_paradas_if.sv
// Bus between the elevator control unit (master) and the passenger stop queue (slave).
interface fila_paradas_if;
    logic       [3:0] chaves;
    logic             select1;
    logic             enableRAM;
    logic             marcaEmbarque;
    logic             shift;
    logic             clearSuperRam;
    logic       [3:0] proxParada;
    logic             vazia;
    logic             cheia;
    logic             origemPendente;
    logic             erro;
    logic       [4:0] db_ocupacao;

    modport master (
        output chaves, select1, enableRAM, marcaEmbarque, shift, clearSuperRam,
        input  proxParada, vazia, cheia, origemPendente, erro, db_ocupacao
    );

    modport slave (
        input  chaves, select1, enableRAM, marcaEmbarque, shift, clearSuperRam,
        output proxParada, vazia, cheia, origemPendente, erro, db_ocupacao
    );
endinterface

// File: rtl/fila_paradas.sv
// Circular FIFO of origin/destination floor pairs with a staging register for the origin.
// Optional FILA_PARADAS_DEDUP_EN rejects a pair already waiting in the queue.
module fila_paradas #(
    parameter int         DEPTH     = 8,
    parameter logic [3:0] MAX_ANDAR = 4'd15
) (
    input logic          clock,
    input logic          reset,
    fila_paradas_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic {
        ESPERA_ORIGEM  = 1'b0,
        ESPERA_DESTINO = 1'b1
    } estado_t;

    estado_t        state, stateNext;
    logic [3:0]     origem  [DEPTH];
    logic [3:0]     destino [DEPTH];
    logic [PW-1:0]  rd, wr;
    logic [OW-1:0]  ocup;
    logic           embarcou;
    logic [3:0]     stg;
    logic           erroReg;

    logic           vaziaInt, cheiaInt;
    logic           chavesOk, dupHit;
    logic           commit, loadStg, errNext, pop;

    assign vaziaInt = (ocup == '0);
    assign cheiaInt = (ocup == OW'(DEPTH));
    assign chavesOk = (bus.chaves != 4'd0) && ({1'b0, bus.chaves} <= {1'b0, MAX_ANDAR});

`ifdef FILA_PARADAS_DEDUP_EN
    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PW-1:0] off;
        dupHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd;
            if (({1'b0, off} < ocup) && (origem[i] == stg) && (destino[i] == bus.chaves))
                dupHit = 1'b1;
        end
    end
`else
    assign dupHit = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        commit    = 1'b0;
        loadStg   = 1'b0;
        errNext   = 1'b0;
        case (state)
            ESPERA_ORIGEM: begin
                if (bus.enableRAM) begin
                    if (bus.select1 && chavesOk) begin
                        loadStg   = 1'b1;
                        stateNext = ESPERA_DESTINO;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            ESPERA_DESTINO: begin
                if (bus.enableRAM) begin
                    if (!bus.select1) begin
                        stateNext = ESPERA_ORIGEM;
                        if (chavesOk && (bus.chaves != stg) && (!cheiaInt || bus.shift) && !dupHit)
                            commit = 1'b1;
                        else
                            errNext = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            default: stateNext = ESPERA_ORIGEM;
        endcase
        // Clear (and reset) override every write decision.
        if (bus.clearSuperRam || !reset) begin
            stateNext = ESPERA_ORIGEM;
            commit    = 1'b0;
            loadStg   = 1'b0;
            errNext   = 1'b0;
        end
    end

    assign pop = bus.shift && !vaziaInt && !bus.clearSuperRam;

    always_ff @(posedge clock) begin
        if (!reset) state <= ESPERA_ORIGEM;
        else        state <= stateNext;
    end

    always_ff @(posedge clock) begin
        if (!reset || bus.clearSuperRam) begin
            rd       <= '0;
            wr       <= '0;
            ocup     <= '0;
            embarcou <= 1'b0;
            stg      <= 4'd0;
            erroReg  <= 1'b0;
        end else begin
            erroReg <= errNext;
            if (loadStg) stg <= bus.chaves;
            if (commit)  wr  <= wr + PW'(1);
            if (pop)     rd  <= rd + PW'(1);
            case ({commit, pop})
                2'b10:   ocup <= ocup + OW'(1);
                2'b01:   ocup <= ocup - OW'(1);
                default: ocup <= ocup;
            endcase
            // Emptiness uses pre-edge state, so boarding into a just-filled queue is ignored.
            if (pop)
                embarcou <= 1'b0;
            else if (bus.marcaEmbarque && !vaziaInt)
                embarcou <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            origem[wr]  <= stg;
            destino[wr] <= bus.chaves;
        end
    end

    assign bus.proxParada     = vaziaInt ? 4'd0 : (embarcou ? destino[rd] : origem[rd]);
    assign bus.vazia          = vaziaInt;
    assign bus.cheia          = cheiaInt;
    assign bus.origemPendente = (state == ESPERA_DESTINO);
    assign bus.erro           = erroReg;
    assign bus.db_ocupacao    = 5'(ocup);
endmodule

// File: tb/tb_fila_paradas.sv
// Directed bench for fila_paradas (DEPTH=8, MAX_ANDAR=15).
module tb_fila_paradas;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fila_paradas_if bus ();

    fila_paradas #(.DEPTH(8), .MAX_ANDAR(4'd15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        bus.chaves = 4'd0; bus.select1 = 1'b0; bus.enableRAM = 1'b0;
        bus.marcaEmbarque = 1'b0; bus.shift = 1'b0; bus.clearSuperRam = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [3:0] v);
        bus.enableRAM = 1'b1; bus.select1 = sel; bus.chaves = v;
        tick();
        bus.enableRAM = 1'b0; bus.select1 = 1'b0; bus.chaves = 4'd0;
    endtask

    task automatic pulseMarca;
        bus.marcaEmbarque = 1'b1; tick(); bus.marcaEmbarque = 1'b0;
    endtask

    task automatic pulseShift;
        bus.shift = 1'b1; tick(); bus.shift = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        vectors++; if (bus.proxParada !== 4'd0) begin miscompares++; $display("FAIL reset_prox got=%0d exp=0", bus.proxParada); end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL reset_vazia got=%b exp=1", bus.vazia); end
        vectors++; if (bus.cheia !== 1'b0) begin miscompares++; $display("FAIL reset_cheia got=%b exp=0", bus.cheia); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL reset_pend got=%b exp=0", bus.origemPendente); end
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL reset_erro got=%b exp=0", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL reset_ocup got=%0d exp=0", bus.db_ocupacao); end
    endtask

    task automatic test_basic;
        wr(1'b1, 4'd3);
        vectors++; if (bus.origemPendente !== 1'b1) begin miscompares++; $display("FAIL basic_pend got=%b exp=1", bus.origemPendente); end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL basic_vazia_staged got=%b exp=1", bus.vazia); end
        wr(1'b0, 4'd7);
        vectors++; if (bus.proxParada !== 4'd3) begin miscompares++; $display("FAIL basic_prox_origem got=%0d exp=3", bus.proxParada); end
        vectors++; if (bus.db_ocupacao !== 5'd1) begin miscompares++; $display("FAIL basic_ocup got=%0d exp=1", bus.db_ocupacao); end
        vectors++; if (bus.vazia !== 1'b0) begin miscompares++; $display("FAIL basic_vazia got=%b exp=0", bus.vazia); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL basic_pend_done got=%b exp=0", bus.origemPendente); end
        pulseMarca();
        vectors++; if (bus.proxParada !== 4'd7) begin miscompares++; $display("FAIL basic_prox_destino got=%0d exp=7", bus.proxParada); end
        pulseShift();
        vectors++; if (bus.proxParada !== 4'd0) begin miscompares++; $display("FAIL basic_prox_pop got=%0d exp=0", bus.proxParada); end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL basic_vazia_pop got=%b exp=1", bus.vazia); end
    endtask

    task automatic test_full;
        for (int i = 1; i <= 8; i++) begin
            wr(1'b1, 4'(i));
            wr(1'b0, 4'(i + 1));
        end
        vectors++; if (bus.cheia !== 1'b1) begin miscompares++; $display("FAIL full_cheia got=%b exp=1", bus.cheia); end
        vectors++; if (bus.db_ocupacao !== 5'd8) begin miscompares++; $display("FAIL full_ocup got=%0d exp=8", bus.db_ocupacao); end
        vectors++; if (bus.proxParada !== 4'd1) begin miscompares++; $display("FAIL full_head got=%0d exp=1", bus.proxParada); end
        wr(1'b1, 4'd9);
        wr(1'b0, 4'd10);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL full_reject_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd8) begin miscompares++; $display("FAIL full_reject_ocup got=%0d exp=8", bus.db_ocupacao); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL full_reject_pend got=%b exp=0", bus.origemPendente); end
        tick();
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL full_erro_oneshot got=%b exp=0", bus.erro); end
        wr(1'b1, 4'd9);
        bus.enableRAM = 1'b1; bus.select1 = 1'b0; bus.chaves = 4'd10; bus.shift = 1'b1;
        tick();
        idle();
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL full_shift_erro got=%b exp=0", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd8) begin miscompares++; $display("FAIL full_shift_ocup got=%0d exp=8", bus.db_ocupacao); end
        vectors++; if (bus.proxParada !== 4'd2) begin miscompares++; $display("FAIL full_shift_head got=%0d exp=2", bus.proxParada); end
        // Drain: remaining pairs are k -> k+1 for k = 2..9.
        for (int k = 2; k <= 9; k++) begin
            vectors++; if (bus.proxParada !== 4'(k)) begin miscompares++; $display("FAIL drain_origem got=%0d exp=%0d", bus.proxParada, k); end
            pulseMarca();
            vectors++; if (bus.proxParada !== 4'(k + 1)) begin miscompares++; $display("FAIL drain_destino got=%0d exp=%0d", bus.proxParada, k + 1); end
            pulseShift();
        end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL drain_vazia got=%b exp=1", bus.vazia); end
    endtask

    task automatic test_invalid;
        wr(1'b1, 4'd0);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL inv_orig0_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL inv_orig0_pend got=%b exp=0", bus.origemPendente); end
        wr(1'b1, 4'd5);
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL inv_orig5_erro got=%b exp=0", bus.erro); end
        wr(1'b0, 4'd5);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL inv_same_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL inv_same_ocup got=%0d exp=0", bus.db_ocupacao); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL inv_same_pend got=%b exp=0", bus.origemPendente); end
        wr(1'b0, 4'd4);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL inv_nopend_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL inv_nopend_ocup got=%0d exp=0", bus.db_ocupacao); end
        wr(1'b1, 4'd5);
        wr(1'b1, 4'd6);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL inv_dblorig_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.origemPendente !== 1'b1) begin miscompares++; $display("FAIL inv_dblorig_pend got=%b exp=1", bus.origemPendente); end
        wr(1'b0, 4'd8);
        vectors++; if (bus.db_ocupacao !== 5'd1) begin miscompares++; $display("FAIL inv_keep_ocup got=%0d exp=1", bus.db_ocupacao); end
        vectors++; if (bus.proxParada !== 4'd5) begin miscompares++; $display("FAIL inv_keep_origem got=%0d exp=5", bus.proxParada); end
        pulseShift();
        pulseShift();
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL shift_empty_erro got=%b exp=0", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL shift_empty_ocup got=%0d exp=0", bus.db_ocupacao); end
    endtask

    task automatic test_simultaneous;
        pulseMarca();
        wr(1'b1, 4'd2);
        bus.enableRAM = 1'b1; bus.select1 = 1'b0; bus.chaves = 4'd11; bus.marcaEmbarque = 1'b1;
        tick();
        idle();
        vectors++; if (bus.proxParada !== 4'd2) begin miscompares++; $display("FAIL marca_into_empty got=%0d exp=2", bus.proxParada); end
        wr(1'b1, 4'd4);
        wr(1'b0, 4'd12);
        pulseMarca();
        vectors++; if (bus.proxParada !== 4'd11) begin miscompares++; $display("FAIL simul_embarque got=%0d exp=11", bus.proxParada); end
        bus.shift = 1'b1; bus.marcaEmbarque = 1'b1;
        tick();
        idle();
        vectors++; if (bus.proxParada !== 4'd4) begin miscompares++; $display("FAIL shift_wins got=%0d exp=4", bus.proxParada); end
        pulseShift();
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL simul_vazia got=%b exp=1", bus.vazia); end
    endtask

    // Pair p: origin (p%14)+1, destination ((p+5)%14)+1.
    task automatic test_wrap;
        for (int p = 0; p < 3; p++) begin
            wr(1'b1, 4'((p % 14) + 1));
            wr(1'b0, 4'(((p + 5) % 14) + 1));
        end
        for (int i = 0; i < 12; i++) begin
            vectors++; if (bus.proxParada !== 4'((i % 14) + 1)) begin miscompares++; $display("FAIL wrap_origem i=%0d got=%0d exp=%0d", i, bus.proxParada, (i % 14) + 1); end
            pulseMarca();
            vectors++; if (bus.proxParada !== 4'(((i + 5) % 14) + 1)) begin miscompares++; $display("FAIL wrap_destino i=%0d got=%0d exp=%0d", i, bus.proxParada, ((i + 5) % 14) + 1); end
            wr(1'b1, 4'(((i + 3) % 14) + 1));
            bus.enableRAM = 1'b1; bus.select1 = 1'b0; bus.chaves = 4'(((i + 8) % 14) + 1); bus.shift = 1'b1;
            tick();
            idle();
            vectors++; if (bus.db_ocupacao !== 5'd3) begin miscompares++; $display("FAIL wrap_ocup i=%0d got=%0d exp=3", i, bus.db_ocupacao); end
        end
        for (int p = 12; p < 15; p++) begin
            vectors++; if (bus.proxParada !== 4'((p % 14) + 1)) begin miscompares++; $display("FAIL wrap_tail_origem p=%0d got=%0d exp=%0d", p, bus.proxParada, (p % 14) + 1); end
            pulseMarca();
            vectors++; if (bus.proxParada !== 4'(((p + 5) % 14) + 1)) begin miscompares++; $display("FAIL wrap_tail_destino p=%0d got=%0d exp=%0d", p, bus.proxParada, ((p + 5) % 14) + 1); end
            pulseShift();
        end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL wrap_vazia got=%b exp=1", bus.vazia); end
    endtask

    task automatic test_clear;
        for (int p = 1; p <= 3; p++) begin
            wr(1'b1, 4'(p));
            wr(1'b0, 4'(p + 4));
        end
        wr(1'b1, 4'd4);
        vectors++; if (bus.origemPendente !== 1'b1) begin miscompares++; $display("FAIL clear_pre_pend got=%b exp=1", bus.origemPendente); end
        bus.clearSuperRam = 1'b1; tick(); bus.clearSuperRam = 1'b0;
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL clear_vazia got=%b exp=1", bus.vazia); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL clear_pend got=%b exp=0", bus.origemPendente); end
        vectors++; if (bus.proxParada !== 4'd0) begin miscompares++; $display("FAIL clear_prox got=%0d exp=0", bus.proxParada); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL clear_ocup got=%0d exp=0", bus.db_ocupacao); end
        wr(1'b0, 4'd5);
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL clear_fsm_origem got=%b exp=1", bus.erro); end
        wr(1'b1, 4'd6);
        wr(1'b0, 4'd9);
        wr(1'b1, 4'd1);
        reset = 1'b0; bus.clearSuperRam = 1'b1;
        bus.enableRAM = 1'b1; bus.select1 = 1'b1; bus.chaves = 4'd2;
        tick();
        vectors++; if (bus.proxParada !== 4'd0) begin miscompares++; $display("FAIL rst_mid_prox got=%0d exp=0", bus.proxParada); end
        vectors++; if (bus.vazia !== 1'b1) begin miscompares++; $display("FAIL rst_mid_vazia got=%b exp=1", bus.vazia); end
        vectors++; if (bus.cheia !== 1'b0) begin miscompares++; $display("FAIL rst_mid_cheia got=%b exp=0", bus.cheia); end
        vectors++; if (bus.origemPendente !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pend got=%b exp=0", bus.origemPendente); end
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL rst_mid_erro got=%b exp=0", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd0) begin miscompares++; $display("FAIL rst_mid_ocup got=%0d exp=0", bus.db_ocupacao); end
        idle();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dedup;
        wr(1'b1, 4'd2);
        wr(1'b0, 4'd6);
        wr(1'b1, 4'd2);
        wr(1'b0, 4'd6);
`ifdef FILA_PARADAS_DEDUP_EN
        vectors++; if (bus.erro !== 1'b1) begin miscompares++; $display("FAIL dedup_erro got=%b exp=1", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd1) begin miscompares++; $display("FAIL dedup_ocup got=%0d exp=1", bus.db_ocupacao); end
`else
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL dup_erro got=%b exp=0", bus.erro); end
        vectors++; if (bus.db_ocupacao !== 5'd2) begin miscompares++; $display("FAIL dup_ocup got=%0d exp=2", bus.db_ocupacao); end
`endif
        wr(1'b1, 4'd2);
        wr(1'b0, 4'd7);
        vectors++; if (bus.erro !== 1'b0) begin miscompares++; $display("FAIL distinct_erro got=%b exp=0", bus.erro); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_invalid();
        test_simultaneous();
        test_wrap();
        test_clear();
        test_dedup();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fila_paradas.md
# fila_paradas

Passenger stop queue for the elevator controller. It is the storage end of the interface that the control unit drives:
- The control unit writes origin/destination floor pairs taken from the `chaves` switches (`select1`, `enableRAM`).
- It acknowledges boarding and advances the queue (`marcaEmbarque`, `shift`).
- It reads back the next floor to serve on `proxParada`.

The block is a circular FIFO of request pairs with a staging register, input validation and an occupancy count.

## Interface
Parameters:
- `DEPTH`, 8: number of request pairs stored (power of two, 2..16).
- `MAX_ANDAR`, 4'd15: highest valid floor; floor 0 is reserved and means "no stop".

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `chaves`  in  4  floor number being entered.
- `select1`  in  1  1 = write is an origin, 0 = write is a destination.
- `enableRAM`  in  1  one-cycle write strobe.
- `marcaEmbarque`  in  1  one-cycle pulse: passenger at head has boarded.
- `shift`  in  1  one-cycle pulse: head destination reached; pop head.
- `clearSuperRam`  in  1  synchronous clear of queue and staging.
- `proxParada`  out  4  next floor to serve; 0 when queue empty.
- `vazia`  out  1  queue empty.
- `cheia`  out  1  queue holds DEPTH pairs.
- `origemPendente`  out  1  staging register holds an origin awaiting its destination.
- `erro`  out  1  one-cycle pulse: last write rejected.
- `db_ocupacao`  out  5  number of stored pairs.

## Operation
- **Storage:** arrays `origem[DEPTH]` and `destino[DEPTH]`, each 4 bits; read pointer `rd` and write pointer `wr`, each log2(DEPTH) bits, wrapping modulo DEPTH; counter `ocup` (0..DEPTH); head flag `embarcou`; staging register `stg` plus `origemPendente`.
- **Write FSM:** two states, `ESPERA_ORIGEM` and `ESPERA_DESTINO`.
- **In `ESPERA_ORIGEM`, on `enableRAM` with `select1=1`:**
  - Accepted when `chaves` is in 1..MAX_ANDAR.
  - On accept: `stg<=chaves`, go to `ESPERA_DESTINO`.
  - Otherwise pulse `erro` and stay.
- **In `ESPERA_DESTINO`, on `enableRAM` with `select1=0`:**
  - Accepted when `chaves` is in 1..MAX_ANDAR, `chaves!=stg`, and the queue is not full (or `shift` is asserted in the same cycle).
  - On accept: commit the pair at `wr`, `wr++`, `ocup++`, return to `ESPERA_ORIGEM`.
  - On reject: pulse `erro`, drop the staged origin, return to `ESPERA_ORIGEM`.
- **Wrong-kind write:** `select1=0` in `ESPERA_ORIGEM`, or `select1=1` in `ESPERA_DESTINO`, pulses `erro` and changes no state. The second case keeps the earlier origin.
- **Read side:** `proxParada` = 0 if empty; else `origem[rd]` if `embarcou=0`; else `destino[rd]`.
- **`marcaEmbarque`:** sets `embarcou` when the queue is non-empty; ignored when empty.
- **`shift`:** when non-empty, `rd++`, `ocup--`, `embarcou<=0`. When empty it is ignored and does not set `erro`.
- **Simultaneous events:**
  - `shift` and a commit in the same cycle: both happen; `ocup` is unchanged. This is legal even when full.
  - `shift` and `marcaEmbarque` together: `shift` wins; `embarcou` ends at 0.
  - Commit into an empty queue with `marcaEmbarque` in the same cycle: `marcaEmbarque` is ignored, because the emptiness check uses the pre-edge state.
- **Priority:** `reset` > `clearSuperRam` > everything else.
  - `clearSuperRam` zeroes `rd`, `wr`, `ocup`, `embarcou`, `stg` and `origemPendente`, and returns the FSM to `ESPERA_ORIGEM`.
  - Array contents need not be cleared.

## Timing
- **Reset values:**
  - `proxParada=0`, `vazia=1`, `cheia=0`, `origemPendente=0`, `erro=0`, `db_ocupacao=0`.
  - FSM in `ESPERA_ORIGEM`.
- **Output timing:** all state is registered. `proxParada`, `vazia`, `cheia` and `db_ocupacao` are combinational from registers and change at the edge that updates them (zero extra latency).
  - `proxParada` shows a committed origin in the cycle after the commit edge.
  - `proxParada` switches to the destination in the cycle after the `marcaEmbarque` edge.
- **`erro`:** registered and high for exactly the one cycle after the offending edge.
- **Inputs:** all inputs are sampled only on the rising edge. Strobes are assumed already edge-detected upstream, so a strobe held high for N cycles acts as N events.
- **Reset mid-operation:** reset asserted during a staged origin discards it; no partial pair is ever committed.

## Configuration
- **`FILA_PARADAS_DEDUP_EN` defined:** a destination write whose (stg, chaves) pair equals any stored, not yet popped pair is rejected: `erro` pulses and the staged origin is dropped. The comparison covers all `ocup` valid entries, including the head.
- **Undefined:** duplicates are accepted as separate entries, and no compare logic is built.

## Test plan
- Reset, then write origin 3 and destination 7 → `proxParada=3`, `db_ocupacao=1`, `vazia=0`. Pulse `marcaEmbarque` → `proxParada=7`. Pulse `shift` → `proxParada=0`, `vazia=1`.
- With DEPTH=8, fill 8 pairs (1→2 … 8→9) → `cheia=1`. The 9th destination write → `erro` for 1 cycle, `db_ocupacao=8`. The 9th destination write issued together with `shift` → accepted, `db_ocupacao=8`, and the head advances to origin 2.
- Invalid writes, each → `erro`, `db_ocupacao` unchanged:
  - origin 0;
  - origin 5 then destination 5;
  - destination write with no pending origin.
- 12 push/pop cycles across a wrap-around with DEPTH=8 → FIFO order preserved; pair 9 is read back as written.
- `clearSuperRam` with 3 pairs stored and an origin staged → next cycle `vazia=1`, `origemPendente=0`, `proxParada=0`. Asserting `reset` low with `clearSuperRam` and `enableRAM` also active → all reset values.
- With `FILA_PARADAS_DEDUP_EN`: push 2→6, then 2→6 again → `erro`, `db_ocupacao=1`. Without the macro → `db_ocupacao=2`.
